// File: rtl/bus_responder.sv
`default_nettype none
// ============================================================================
// Module   : bus_responder
// Purpose  : CPU bus target with aliased word RAM, TX byte FIFO and a free-running
//            cycle counter with snapshot.
// Revision : 1.0 - initial release
// ============================================================================
module bus_responder #(
    parameter int          RAM_AW    = 12,
    parameter logic [15:0] IO_BASE   = 16'hFF00,
    parameter int          FIFO_AW   = 3,
    parameter string       INIT_FILE = "ram.in"
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] a,
    inout  wire  [7:0]  d,
    input  logic        oe,
    input  logic        we,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int               c_depth     = 2 ** FIFO_AW;
    localparam int               c_ram_words = 2 ** RAM_AW;
    localparam logic [FIFO_AW:0] c_full_cnt  = {1'b1, {FIFO_AW{1'b0}}};

    logic [7:0]         r_mem  [0:c_ram_words-1];
    logic [7:0]         r_fifo [0:c_depth-1];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_AW:0]   r_count;
    logic               r_ovf;
    logic               r_we_q;
    logic [15:0]        r_cycle;
    logic [15:0]        r_snap;

    logic               w_io_sel;
    logic               w_commit;
    logic               w_ram_wr;
    logic               w_push_req;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic               w_stat_wr;
    logic               w_snap_wr;
    logic [3:0]         w_cnt4;
    logic [7:0]         w_status;
    logic [7:0]         w_rdata;

    assign w_io_sel   = (a >= IO_BASE);
    // A write commits only on the falling transition of we, and never in reset.
    assign w_commit   = rst & ~we & r_we_q;
    assign w_ram_wr   = w_commit & ~w_io_sel;
    assign w_push_req = w_commit & w_io_sel & (a[7:0] == 8'h00);
    assign w_stat_wr  = w_commit & w_io_sel & (a[7:0] == 8'h01);
    assign w_snap_wr  = w_commit & w_io_sel & (a[7:0] == 8'h02);

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == c_full_cnt);
    assign w_pop      = ~w_empty & tx_ready;
    assign w_push     = w_push_req & (~w_full | w_pop);

    assign tx_valid   = ~w_empty;
    assign tx_data    = r_fifo[r_rd_ptr];

    generate
        if (FIFO_AW >= 4) begin : g_cnt_sat
            assign w_cnt4 = (r_count > (FIFO_AW + 1)'(15)) ? 4'hF : r_count[3:0];
        end else begin : g_cnt_nosat
            assign w_cnt4 = 4'(r_count);
        end
    endgenerate

    assign w_status = {w_cnt4, 1'b0, r_ovf, w_empty, w_full};

    always_comb begin
        w_rdata = 8'h00;
        if (!w_io_sel) begin
            w_rdata = r_mem[a[RAM_AW-1:0]];
        end else begin
            case (a[7:0])
                8'h01:   w_rdata = w_status;
                8'h02:   w_rdata = r_snap[7:0];
                8'h03:   w_rdata = r_snap[15:8];
                default: w_rdata = 8'h00;
            endcase
        end
    end

    // Asynchronous-memory style read; a simultaneous write keeps the bus released.
    assign d = (!oe && we) ? w_rdata : 8'hzz;

    always_ff @(posedge clk) begin
        if (w_ram_wr) begin
            r_mem[a[RAM_AW-1:0]] <= d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_we_q   <= 1'b0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_cycle  <= 16'h0000;
            r_snap   <= 16'h0000;
            for (int i = 0; i < c_depth; i++) begin
                r_fifo[i] <= 8'h00;
            end
        end else begin
            r_we_q  <= we;
            r_cycle <= r_cycle + 16'd1;
            if (w_push) begin
                r_fifo[r_wr_ptr] <= d;
                r_wr_ptr         <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_push_req && w_full && !w_pop) begin
                r_ovf <= 1'b1;
            end else if (w_stat_wr && d[2]) begin
                r_ovf <= 1'b0;
            end
            if (w_snap_wr) begin
                r_snap <= r_cycle;
            end
        end
    end

endmodule
`default_nettype wire
